// File: rtl/mk_multi_accumulator.sv
// Multi-channel signed accumulator with sticky per-channel overflow and a registered read/clear port.
// Optional build macro ACCUMULATOR_SATURATE_EN clamps sums on overflow instead of wrapping.
module mk_multi_accumulator #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 40,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_CLK,
    input  logic                i_RESET_N,
    input  logic                i_ENABLE,
    input  logic [CH_W-1:0]     i_CHANNEL,
    input  logic [DATA_W-1:0]   i_DATA_IN,
    input  logic                i_CLEAR_ALL,
    input  logic                i_RD_EN,
    input  logic [CH_W-1:0]     i_RD_CHANNEL,
    input  logic                i_RD_CLEAR,
    output logic                o_RD_VALID,
    output logic [ACC_W-1:0]    o_RD_DATA,
    output logic                o_RD_OVERFLOW,
    output logic [CHANNELS-1:0] o_OVERFLOW
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Same-sign operands producing an opposite-sign result means signed overflow.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    logic [ACC_W-1:0]    sum_q [CHANNELS];
    logic [ACC_W-1:0]    sum_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ACC_W-1:0]    rd_data_q, rd_data_d;
    logic                rd_ovf_q, rd_ovf_d;

    logic signed [DATA_W-1:0] din_s;
    logic signed [ACC_W-1:0]  ext_s;
    logic [ACC_W-1:0]         base_s, raw_s;
    logic                     flag_s, ovf_s;

    assign din_s = i_DATA_IN;
    assign ext_s = ACC_W'(din_s);

    // Next-state for every channel: read-clear first, then accumulate, clear-all overrides both.
    always_comb begin
        base_s = {ACC_W{1'b0}};
        raw_s  = {ACC_W{1'b0}};
        flag_s = 1'b0;
        ovf_s  = 1'b0;
        ovf_d  = ovf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_d[c] = sum_q[c];
            base_s   = sum_q[c];
            flag_s   = ovf_q[c];
            if (i_RD_EN && i_RD_CLEAR && (i_RD_CHANNEL == CH_W'(c))) begin
                base_s = {ACC_W{1'b0}};
                flag_s = 1'b0;
            end else begin
                base_s = sum_q[c];
            end
            raw_s = base_s + ext_s;
            ovf_s = add_ovf(base_s[ACC_W-1], ext_s[ACC_W-1], raw_s[ACC_W-1]);
            if (i_CLEAR_ALL) begin
                sum_d[c] = {ACC_W{1'b0}};
                ovf_d[c] = 1'b0;
            end else if (i_ENABLE && (i_CHANNEL == CH_W'(c))) begin
                ovf_d[c] = flag_s | ovf_s;
`ifdef ACCUMULATOR_SATURATE_EN
                if (ovf_s) begin
                    sum_d[c] = base_s[ACC_W-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    sum_d[c] = raw_s;
                end
`else
                sum_d[c] = raw_s;
`endif
            end else begin
                sum_d[c] = base_s;
                ovf_d[c] = flag_s;
            end
        end
    end

    // Read port samples pre-update state; out-of-range channels read as zero.
    always_comb begin
        rd_valid_d = i_RD_EN;
        rd_data_d  = rd_data_q;
        rd_ovf_d   = rd_ovf_q;
        if (i_RD_EN) begin
            rd_data_d = {ACC_W{1'b0}};
            rd_ovf_d  = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (i_RD_CHANNEL == CH_W'(c)) begin
                    rd_data_d = sum_q[c];
                    rd_ovf_d  = ovf_q[c];
                end else begin
                    rd_data_d = rd_data_d;
                end
            end
        end else begin
            rd_data_d = rd_data_q;
            rd_ovf_d  = rd_ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= {ACC_W{1'b0}};
            end
            ovf_q      <= {CHANNELS{1'b0}};
            rd_valid_q <= 1'b0;
            rd_data_q  <= {ACC_W{1'b0}};
            rd_ovf_q   <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_q[c] <= sum_d[c];
            end
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign o_RD_VALID    = rd_valid_q;
    assign o_RD_DATA     = rd_data_q;
    assign o_RD_OVERFLOW = rd_ovf_q;
    assign o_OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_mk_multi_accumulator.sv
// Scoreboard bench for mk_multi_accumulator; reference model uses plain 64-bit integer arithmetic.
// Honours ACCUMULATOR_SATURATE_EN so it matches whichever build is compiled.
module tb_mk_multi_accumulator;

    localparam int CHANNELS = 4;
    localparam int DATA_W   = 32;
    localparam int ACC_W    = 40;
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));
    localparam longint SPAN = 64'sd1 <<< ACC_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0, clr_all = 1'b0, rd = 1'b0, rd_clr = 1'b0;
    logic [CH_W-1:0]     ch = '0, rd_ch = '0;
    logic [DATA_W-1:0]   din = '0;
    logic                rd_valid, rd_ovf;
    logic [ACC_W-1:0]    rd_data;
    logic [CHANNELS-1:0] ovf;

    mk_multi_accumulator #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .i_CLK(clk), .i_RESET_N(rst_n), .i_ENABLE(en), .i_CHANNEL(ch), .i_DATA_IN(din),
        .i_CLEAR_ALL(clr_all), .i_RD_EN(rd), .i_RD_CHANNEL(rd_ch), .i_RD_CLEAR(rd_clr),
        .o_RD_VALID(rd_valid), .o_RD_DATA(rd_data), .o_RD_OVERFLOW(rd_ovf), .o_OVERFLOW(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { longint sum; bit flag; } rd_exp_t;
    rd_exp_t exp_q[$];

    longint              m_sum [CHANNELS];
    bit                  m_flag[CHANNELS];
    bit                  prev_rd = 1'b0;
    bit                  exp_valid_cur = 1'b0;
    logic [CHANNELS-1:0] exp_ovf_cur = '0;
    logic [ACC_W-1:0]    last_data = '0;
    int                  vectors = 0;
    int                  miscompares = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_sum[c]  = 0;
            m_flag[c] = 1'b0;
        end
    endtask

    // One clock of stimulus; expected read data is pushed before the model absorbs this cycle's updates.
    task automatic step(input bit e, input int c, input longint d, input bit ca,
                        input bit r, input int rc, input bit rclr);
        longint t;
        @(posedge clk);
        #1;
        exp_valid_cur = prev_rd;
        for (int k = 0; k < CHANNELS; k++) exp_ovf_cur[k] = m_flag[k];
        en = e; ch = CH_W'(c); din = DATA_W'(d); clr_all = ca;
        rd = r; rd_ch = CH_W'(rc); rd_clr = rclr;
        if (r) exp_q.push_back('{sum: m_sum[rc], flag: m_flag[rc]});
        prev_rd = r;
        if (ca) begin
            model_reset();
        end else begin
            if (r && rclr) begin
                m_sum[rc]  = 0;
                m_flag[rc] = 1'b0;
            end
            if (e) begin
                t = m_sum[c] + longint'($signed(din));
                if (t > MAXV || t < MINV) m_flag[c] = 1'b1;
`ifdef ACCUMULATOR_SATURATE_EN
                if (t > MAXV) t = MAXV;
                if (t < MINV) t = MINV;
`else
                if (t > MAXV) t = t - SPAN;
                if (t < MINV) t = t + SPAN;
`endif
                m_sum[c] = t;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compares live flags, valid timing, and pops the scoreboard whenever a read returns.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_valid", longint'(rd_valid), longint'(exp_valid_cur));
            check("overflow_flags", longint'(ovf), longint'(exp_ovf_cur));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", 64'sd1, 64'sd0);
                end else begin
                    rd_exp_t e;
                    logic [ACC_W-1:0] ed;
                    e  = exp_q.pop_front();
                    ed = e.sum[ACC_W-1:0];
                    check("rd_data", longint'(rd_data), longint'(ed));
                    check("rd_overflow", longint'(rd_ovf), longint'(e.flag));
                end
                last_data = rd_data;
            end else begin
                check("rd_data_hold", longint'(rd_data), longint'(last_data));
            end
        end
    end

    initial begin
        model_reset();
        #3;
        check("reset_rd_valid", longint'(rd_valid), 0);
        check("reset_rd_data", longint'(rd_data), 0);
        check("reset_rd_overflow", longint'(rd_ovf), 0);
        check("reset_overflow", longint'(ovf), 0);
        #9 rst_n = 1'b1;

        // Per-channel sums.
        step(1'b1, 0, 5, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 0, 7, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 0, -3, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 2, 100, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 2, 1'b0);
        // Negative input.
        step(1'b1, 1, 32'hFFFF_FFE0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1, 32'hFFFF_FFE0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1, 1'b0);
        // Positive overflow on ch3: 256 max samples then push past the limit, then keep pushing.
        for (int i = 0; i < 256; i++) step(1'b1, 3, 32'h7FFF_FFFF, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b0);
        step(1'b1, 3, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b0);
        step(1'b1, 3, 32'h0000_0010, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 3, 1'b0);
        idle(); idle();
        // Read-clear collision: clear ch0 to 50 first via read-clear, then collide.
        step(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b1);
        step(1'b1, 0, 50, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 0, 8, 1'b0, 1'b1, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1, 0, 1'b0);
        // Clear-all priority with concurrent accumulate and read.
        step(1'b1, 2, 9, 1'b1, 1'b1, 2, 1'b0);
        for (int c = 0; c < CHANNELS; c++) step(1'b0, 0, 0, 1'b0, 1'b1, c, 1'b0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom_range(0, CHANNELS - 1),
                 longint'($signed(32'($urandom()))), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)), $urandom_range(0, CHANNELS - 1),
                 1'($urandom_range(0, 3) == 0));
        end
        // Drive ch1 into flag, then asynchronous reset mid-read.
        for (int i = 0; i < 300; i++) step(1'b1, 1, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 0, 11, 1'b0, 1'b1, 1, 1'b0);
        step(1'b1, 2, 13, 1'b0, 1'b1, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rd_valid", longint'(rd_valid), 0);
        check("async_reset_overflow", longint'(ovf), 0);
        en = 1'b0; rd = 1'b0; clr_all = 1'b0; rd_clr = 1'b0;
        model_reset();
        exp_q.delete();
        prev_rd = 1'b0; exp_valid_cur = 1'b0; exp_ovf_cur = '0; last_data = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < CHANNELS; c++) step(1'b0, 0, 0, 1'b0, 1'b1, c, 1'b0);
        idle(); idle();
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
